// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
module fifo_sync_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              ren,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wptr;
  logic [CW-1:0]     rptr;
  logic              rd_ok;
  logic              wr_ok;
  logic [CW-1:0]     count_nxt;

  // Flags depend on registered count only, so wen/ren never reach an output.
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign afull  = (count >= AFULL_C);
  assign aempty = (count <= AEMPTY_C);

  // A full FIFO still takes a write when the same edge drains one entry.
  assign rd_ok = ren & ~empty;
  assign wr_ok = wen & (~full | rd_ok);

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage: not reset; a gated write in the reset cycle is harmless because wptr is cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + CW'(1);
      end
      if (rd_ok) begin
        rdata <= mem[rptr[AW-1:0]];
        rptr  <= rptr + CW'(1);
      end
      rvalid <= rd_ok;
      count  <= count_nxt;
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (ren && !rd_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a queue model of the FIFO contents feeds
// an expected-read queue that is compared against rdata whenever a read completes.
module tb_fifo_sync_param;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              wen = 1'b0;
  logic              ren = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              full, empty, afull, aempty;
  logic [CW-1:0]     count;
  logic              overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_rv;
  logic [DATA_W-1:0] exp_d;
  logic [3:0]        exp_flags;

  fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .ren(ren), .clr_err(clr_err),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty), .afull(afull),
    .aempty(aempty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and advance the reference queue model.
  task automatic drive(input logic w, input logic r, input logic [DATA_W-1:0] d, input logic c);
    bit rd_ok, wr_ok;
    rd_ok = r && (model_q.size() != 0);
    wr_ok = w && ((model_q.size() != DEPTH) || rd_ok);
    wen = w; ren = r; wdata = d; clr_err = c;
    @(posedge clk);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    exp_rv = rd_ok;
    #1;
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 16'hDEAD;
    @(posedge clk); #1;
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    model_q.delete(); exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({count, empty, aempty, full, afull} !== {CW'(0), 4'b1100})
        begin errors++; $display("FAIL reset_flags cyc%0d: got cnt=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0", i, count, empty, aempty, full, afull); end
      checks++;
      if ({rvalid, overflow, underflow} !== 3'b000)
        begin errors++; $display("FAIL reset_ctrl cyc%0d: got rv/ovf/udf=%b, want 000", i, {rvalid, overflow, underflow}); end
      checks++;
      if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h, want 0000", rdata); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      if (i < 8) drive(1'b1, 1'b0, 16'hA000 + 16'(i), 1'b0);
      else       drive(1'b0, 1'b1, 16'h0000, 1'b0);
      exp_flags = {model_q.size() == DEPTH, model_q.size() >= 6, model_q.size() == 0, model_q.size() <= 2};
      checks++;
      if (count !== CW'(model_q.size()))
        begin errors++; $display("FAIL fill_count cyc%0d: got %0d, want %0d", i, count, model_q.size()); end
      checks++;
      if ({full, afull, empty, aempty} !== exp_flags)
        begin errors++; $display("FAIL fill_flags cyc%0d: got f/af/e/ae=%b, want %b", i, {full, afull, empty, aempty}, exp_flags); end
      checks++;
      if (rvalid !== exp_rv) begin errors++; $display("FAIL fill_rvalid cyc%0d: got %b, want %b", i, rvalid, exp_rv); end
      if (exp_rv && exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        checks++;
        if (rdata !== exp_d) begin errors++; $display("FAIL drain_data cyc%0d: got %h, want %h", i, rdata, exp_d); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'hB000 + 16'(i), 1'b0);
    drive(1'b1, 1'b0, 16'hBEEF, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, want 1", overflow); end
    checks++;
    if (count !== CW'(8) || full !== 1'b1)
      begin errors++; $display("FAIL ovf_count: got cnt=%0d full=%b, want 8 1", count, full); end
    drive(1'b1, 1'b0, 16'hBEEF, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_new: got %b, want 1", overflow); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, want 0", overflow); end
  endtask

  task automatic test_full_rw();
    drive(1'b1, 1'b1, 16'h1234, 1'b0);
    exp_d = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_d)
      begin errors++; $display("FAIL full_rw_data: got rv=%b %h, want 1 %h", rvalid, rdata, exp_d); end
    checks++;
    if (count !== CW'(8) || overflow !== 1'b0)
      begin errors++; $display("FAIL full_rw_count: got cnt=%0d ovf=%b, want 8 0", count, overflow); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'h0000, 1'b0);
      exp_d = exp_q.pop_front();
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_d)
        begin errors++; $display("FAIL full_rw_drain%0d: got rv=%b %h, want 1 %h", i, rvalid, rdata, exp_d); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %b, want 1", empty); end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 1'b1, 16'h5555, 1'b0);
    checks++;
    if ({underflow, rvalid} !== 2'b10)
      begin errors++; $display("FAIL udf_set: got udf/rv=%b, want 10", {underflow, rvalid}); end
    checks++;
    if (count !== CW'(1)) begin errors++; $display("FAIL udf_count: got %0d, want 1", count); end
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    exp_d = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'h5555 || rdata !== exp_d)
      begin errors++; $display("FAIL udf_readback: got rv=%b %h, want 1 5555", rvalid, rdata); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b, want 0", underflow); end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i >= 3), 16'hC000 + 16'(i), 1'b0);
      checks++;
      if (rvalid !== exp_rv || count !== CW'(model_q.size()))
        begin errors++; $display("FAIL wrap_ctrl cyc%0d: got rv=%b cnt=%0d, want %b %0d", i, rvalid, count, exp_rv, model_q.size()); end
      if (exp_rv && exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        checks++;
        if (rdata !== exp_d) begin errors++; $display("FAIL wrap_data cyc%0d: got %h, want %h", i, rdata, exp_d); end
      end
    end
    rst = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 16'hFFFF;
    @(posedge clk); #1;
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    model_q.delete(); exp_q.delete();
    checks++;
    if ({count, rvalid, empty} !== {CW'(0), 2'b01})
      begin errors++; $display("FAIL wrap_reset: got cnt=%0d rv=%b e=%b, want 0 0 1", count, rvalid, empty); end
    drive(1'b1, 1'b0, 16'h7777, 1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    exp_d = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 16'h7777 || rdata !== exp_d)
      begin errors++; $display("FAIL post_reset_rw: got rv=%b %h, want 1 7777", rvalid, rdata); end
  endtask

  initial begin
    exp_rv = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
